// File: rtl/pmu_addr_arbiter.sv
// Two-requester round-robin arbiter for the PMU address generator command port.
// Burst-granular grants with a burst-length cap, followed by one registered output stage.
module pmu_addr_arbiter #(
  parameter int DATA_W    = 40,
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid_i,
  input  logic [DATA_W-1:0] req0_data_i,
  input  logic              req0_last_i,
  output logic              req0_ready_o,
  input  logic              req1_valid_i,
  input  logic [DATA_W-1:0] req1_data_i,
  input  logic              req1_last_i,
  output logic              req1_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_src_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic [1:0]        grant_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic               ptr_q, ptr_d;

  logic               vld_p1;
  logic [DATA_W-1:0]  data_p1;
  logic               src_p1;

  logic               slot_free;
  logic               load;
  logic               load_src;
  logic               load_last;
  logic [DATA_W-1:0]  load_data;

  // The output slot can take a word when empty or when it drains this cycle.
  assign slot_free = !vld_p1 || out_ready_i;
  assign cnt_inc   = cnt_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    load         = 1'b0;
    load_src     = 1'b0;
    load_last    = 1'b0;
    load_data    = req0_data_i;

    case (state_q)
      IDLE: begin
        if (req0_valid_i && req1_valid_i)
          state_d = ptr_q ? GRANT1 : GRANT0;
        else if (req0_valid_i)
          state_d = GRANT0;
        else if (req1_valid_i)
          state_d = GRANT1;
      end
      GRANT0: begin
        req0_ready_o = slot_free;
        if (req0_valid_i && slot_free) begin
          load      = 1'b1;
          load_src  = 1'b0;
          load_last = req0_last_i;
          load_data = req0_data_i;
        end
      end
      GRANT1: begin
        req1_ready_o = slot_free;
        if (req1_valid_i && slot_free) begin
          load      = 1'b1;
          load_src  = 1'b1;
          load_last = req1_last_i;
          load_data = req1_data_i;
        end
      end
      default: state_d = IDLE;
    endcase

    // Release the grant on burst end or when the cap is hit; hand priority to the other side.
    if (load) begin
      if (load_last || (cnt_inc == CNT_W'(MAX_BURST))) begin
        state_d = IDLE;
        cnt_d   = '0;
        ptr_d   = ~load_src;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      src_p1  <= 1'b0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      data_p1 <= load_data;
      src_p1  <= load_src;
    end else if (out_ready_i) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid_o = vld_p1;
  assign out_data_o  = data_p1;
  assign out_src_o   = src_p1;
  assign busy_o      = (state_q != IDLE) || vld_p1;
  assign grant_o     = {state_q == GRANT1, state_q == GRANT0};

endmodule

// File: tb/tb_pmu_addr_arbiter.sv
// Bench for pmu_addr_arbiter: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of grants, burst caps and the output slot.
module tb_pmu_addr_arbiter;
  localparam int DW = 40;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid_i, req0_last_i, req0_ready_o;
  logic [DW-1:0] req0_data_i;
  logic          req1_valid_i, req1_last_i, req1_ready_o;
  logic [DW-1:0] req1_data_i;
  logic          out_valid_o, out_src_o, out_ready_i, busy_o;
  logic [DW-1:0] out_data_o;
  logic [1:0]    grant_o;

  always #5 clk = ~clk;

  pmu_addr_arbiter #(.DATA_W(DW), .MAX_BURST(MB), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid_i(req0_valid_i), .req0_data_i(req0_data_i), .req0_last_i(req0_last_i),
    .req0_ready_o(req0_ready_o),
    .req1_valid_i(req1_valid_i), .req1_data_i(req1_data_i), .req1_last_i(req1_last_i),
    .req1_ready_o(req1_ready_o),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_src_o(out_src_o),
    .out_ready_i(out_ready_i), .busy_o(busy_o), .grant_o(grant_o)
  );

  // Requester word queues: {last, data}; consumed words: {src, data}.
  logic [DW:0] q0[$], q1[$], cons_q[$], exp_q[$];
  bit          en0 = 1'b1, en1 = 1'b1;

  // Model: who owns the grant (-1 none), words taken this grant, priority, output slot.
  int          m_owner, m_cnt, m_ptr;
  bit          m_ov, m_os;
  logic [DW-1:0] m_od;

  int n_chk = 0, n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit mrdy(input int i);
    return (m_owner == i) && (!m_ov || out_ready_i);
  endfunction

  task automatic drive();
    req0_valid_i = en0 && (q0.size() > 0);
    req0_data_i  = (q0.size() > 0) ? q0[0][DW-1:0] : '0;
    req0_last_i  = (q0.size() > 0) ? q0[0][DW] : 1'b0;
    req1_valid_i = en1 && (q1.size() > 0);
    req1_data_i  = (q1.size() > 0) ? q1[0][DW-1:0] : '0;
    req1_last_i  = (q1.size() > 0) ? q1[0][DW] : 1'b0;
  endtask

  task automatic model_step();
    int old;
    bit acc, v;
    logic [DW:0] w;
    if (!rst_n) begin
      m_owner = -1; m_cnt = 0; m_ptr = 0; m_ov = 0; m_os = 0; m_od = '0;
      return;
    end
    old = m_owner;
    v   = (old == 0) ? req0_valid_i : req1_valid_i;
    acc = (old >= 0) && v && mrdy(old);
    if (m_ov && out_ready_i) cons_q.push_back({m_os, m_od});
    if (acc) begin
      w = (old == 0) ? q0.pop_front() : q1.pop_front();
      m_ov = 1; m_od = w[DW-1:0]; m_os = (old == 1);
      m_cnt++;
      if (w[DW] || m_cnt == MB) begin
        m_owner = -1; m_cnt = 0; m_ptr = 1 - old;
      end
    end else if (out_ready_i) begin
      m_ov = 0;
    end
    if (old < 0) begin
      if (req0_valid_i && req1_valid_i) m_owner = m_ptr;
      else if (req0_valid_i)            m_owner = 0;
      else if (req1_valid_i)            m_owner = 1;
    end
  endtask

  task automatic compare();
    logic [1:0] g;
    g = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    check("out_valid", out_valid_o, m_ov);
    if (m_ov) begin
      check("out_data", out_data_o, m_od);
      check("out_src", out_src_o, m_os);
    end
    check("grant", grant_o, g);
    check("busy", busy_o, (m_owner >= 0) || m_ov);
    check("req0_ready", req0_ready_o, mrdy(0));
    check("req1_ready", req1_ready_o, mrdy(1));
  endtask

  task automatic tick();
    drive();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  task automatic run_until_idle(input string nm);
    int k = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_owner >= 0 || m_ov) && k < 300) begin
      tick();
      k++;
    end
    if (k >= 300) check({nm, "_timeout"}, 1, 0);
  endtask

  task automatic check_cons(input string nm);
    check({nm, "_count"}, cons_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check(nm, (i < cons_q.size()) ? cons_q[i] : {(DW+1){1'bx}}, exp_q[i]);
  endtask

  function automatic logic [DW:0] wd(input bit last, input logic [DW-1:0] d);
    return {last, d};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; out_ready_i = 1'b1;
    m_owner = -1; m_cnt = 0; m_ptr = 0; m_ov = 0; m_os = 0; m_od = '0;
    drive();

    // Reset held with both requesters valid.
    q0.push_back(wd(1, 40'h11_0000_0001));
    q1.push_back(wd(1, 40'h22_0000_0001));
    do_reset(3);
    check("rst_grant", grant_o, 2'b00);
    check("rst_out_valid", out_valid_o, 1'b0);
    check("rst_out_data", out_data_o, 40'h0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_ready", {req0_ready_o, req1_ready_o}, 2'b00);
    tick();
    check("first_grant", grant_o, 2'b01);
    cons_q.delete();
    run_until_idle("rst_drain");
    exp_q = '{wd(0, 40'h11_0000_0001), wd(1, 40'h22_0000_0001)};
    check_cons("rst_order");

    // Single word latency.
    do_reset(2);
    cons_q.delete();
    q0.push_back(wd(1, 40'h00_0000_C0AA));
    tick();
    check("single_grant_c1", grant_o, 2'b01);
    tick();
    check("single_valid_c2", out_valid_o, 1'b1);
    check("single_data_c2", out_data_o, 40'h00_0000_C0AA);
    check("single_src_c2", out_src_o, 1'b0);
    check("single_grant_c2", grant_o, 2'b00);
    run_until_idle("single");

    // Contention, pointer at 0 then at 1.
    do_reset(2);
    cons_q.delete();
    q0.push_back(wd(0, 40'hA0)); q0.push_back(wd(1, 40'hA1));
    q1.push_back(wd(0, 40'hB0)); q1.push_back(wd(1, 40'hB1));
    run_until_idle("cont1");
    exp_q = '{wd(0, 40'hA0), wd(0, 40'hA1), wd(1, 40'hB0), wd(1, 40'hB1)};
    check_cons("cont1_order");
    q0.push_back(wd(1, 40'hA9));
    run_until_idle("cont_solo");
    cons_q.delete();
    q0.push_back(wd(0, 40'hA2)); q0.push_back(wd(1, 40'hA3));
    q1.push_back(wd(0, 40'hB2)); q1.push_back(wd(1, 40'hB3));
    run_until_idle("cont2");
    exp_q = '{wd(1, 40'hB2), wd(1, 40'hB3), wd(0, 40'hA2), wd(0, 40'hA3)};
    check_cons("cont2_order");

    // Burst cap: req1 streams 6 words without last while req0 waits.
    do_reset(2);
    cons_q.delete();
    for (int i = 0; i < 6; i++) q1.push_back(wd(0, 40'hC0 + 40'(i)));
    en0 = 1'b0;
    tick();
    en0 = 1'b1;
    q0.push_back(wd(0, 40'hD0)); q0.push_back(wd(1, 40'hD1));
    for (int k = 0; k < 100 && cons_q.size() < 8; k++) tick();
    exp_q = '{wd(1, 40'hC0), wd(1, 40'hC1), wd(1, 40'hC2), wd(1, 40'hC3),
              wd(0, 40'hD0), wd(0, 40'hD1), wd(1, 40'hC4), wd(1, 40'hC5)};
    check_cons("cap_order");

    // Backpressure for 5 cycles during a 3-word burst.
    do_reset(2);
    cons_q.delete();
    q0.push_back(wd(0, 40'hE0)); q0.push_back(wd(0, 40'hE1)); q0.push_back(wd(1, 40'hE2));
    tick();
    tick();
    out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_data_hold", out_data_o, 40'hE0);
      check("bp_ready_low", req0_ready_o, 1'b0);
    end
    out_ready_i = 1'b1;
    run_until_idle("bp");
    exp_q = '{wd(0, 40'hE0), wd(0, 40'hE1), wd(0, 40'hE2)};
    check_cons("bp_order");

    // Reset in the middle of a 4-word req0 burst.
    do_reset(2);
    for (int i = 0; i < 4; i++) q0.push_back(wd(i == 3, 40'hF0 + 40'(i)));
    tick(); tick(); tick();
    rst_n = 1'b0;
    q0.delete();
    tick();
    check("mid_rst_valid", out_valid_o, 1'b0);
    check("mid_rst_grant", grant_o, 2'b00);
    rst_n = 1'b1;
    cons_q.delete();
    q1.push_back(wd(0, 40'h55)); q1.push_back(wd(1, 40'h56));
    run_until_idle("mid_rst");
    exp_q = '{wd(1, 40'h55), wd(1, 40'h56)};
    check_cons("mid_rst_order");

    // Random traffic with random backpressure and valid gaps.
    for (int c = 0; c < 3000; c++) begin
      out_ready_i = ($urandom_range(0, 3) != 0);
      en0 = ($urandom_range(0, 3) != 0);
      en1 = ($urandom_range(0, 3) != 0);
      if (q0.size() < 3 && $urandom_range(0, 4) == 0) begin
        int len = $urandom_range(1, 10);
        for (int i = 0; i < len; i++) q0.push_back(wd(i == len - 1, {8'h0A, 32'($urandom)}));
      end
      if (q1.size() < 3 && $urandom_range(0, 4) == 0) begin
        int len = $urandom_range(1, 10);
        for (int i = 0; i < len; i++) q1.push_back(wd(i == len - 1, {8'h0B, 32'($urandom)}));
      end
      tick();
    end
    en0 = 1'b1; en1 = 1'b1; out_ready_i = 1'b1;
    run_until_idle("rand_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pmu_addr_arbiter.md
Name: pmu_addr_arbiter

Overview:
- Arbitrates two 40-bit command sources for the shared PMU address generator (address/data word format, 40 bits).
  - Requester 0: bitstream decrypt path.
  - Requester 1: config/test port.
- Round-robin, burst-granular arbitration, with a burst-length cap against starvation.
- One registered output stage with valid/ready handshake; downstream feeds address_generator data_i.

Parameters:
- DATA_W, 40, width of command words (address_generator data_i width).
- MAX_BURST, 8, maximum words accepted per grant before forced release; legal range 1..255.
- CNT_W, 8, width of burst counter; must hold MAX_BURST.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req0_valid_i  input  1  requester 0 word valid.
- req0_data_i  input  DATA_W  requester 0 command word.
- req0_last_i  input  1  requester 0 final word of burst.
- req0_ready_o  output  1  requester 0 word accepted this cycle (when valid).
- req1_valid_i  input  1  requester 1 word valid.
- req1_data_i  input  DATA_W  requester 1 command word.
- req1_last_i  input  1  requester 1 final word of burst.
- req1_ready_o  output  1  requester 1 word accepted this cycle (when valid).
- out_valid_o  output  1  out_data_o holds a valid word.
- out_data_o  output  DATA_W  word to address_generator data_i.
- out_src_o  output  1  source of current out word (0/1).
- out_ready_i  input  1  downstream consumes word this cycle.
- busy_o  output  1  FSM not in IDLE or out_valid_o high.
- grant_o  output  2  one-hot current grant (00 in IDLE).

Behaviour:
- Reset (rst_n low at clk edge):
  - State = IDLE, grant_o = 00, out_valid_o = 0, out_data_o = 0, out_src_o = 0.
  - Both ready outputs = 0, busy_o = 0, burst counter = 0, priority pointer = requester 0.
- FSM states:
  - IDLE
    - Neither valid: stay.
    - One valid: go to GRANTx for it.
    - Both valid: go to GRANT of the pointer's requester.
    - No words accepted in IDLE; readies = 0.
  - GRANT0 / GRANT1
    - reqx_ready_o = !out_valid_o | out_ready_i (combinational); other requester's ready = 0.
    - Handshake = valid & ready: load out register with data, out_src_o = x, out_valid_o = 1; burst counter += 1.
    - Exit to IDLE on the handshake cycle if last_i = 1 or counter+1 == MAX_BURST.
    - On exit: counter cleared; pointer set to the other requester.
    - Valid low while granted: stay granted, no timeout.
- Out register:
  - Clears out_valid_o when out_ready_i = 1 and no new load.
  - Load and drain in the same cycle: new word replaces old, out_valid_o stays 1.
  - While out_valid_o = 1 and out_ready_i = 0, out_data_o and out_src_o are held stable.
- Latency:
  - Valid in IDLE at cycle N → grant at N+1 → earliest handshake at N+1 → out_valid_o at N+2.
  - Back-to-back words in a burst: 1 word/cycle with out_ready_i held high.
  - One bubble cycle per grant change.
- Counter saturation: MAX_BURST = 1 gives a single word per grant, alternating when both requesters are valid.
- Reset mid-burst:
  - Burst is abandoned and the out word dropped (out_valid_o = 0 next cycle).
  - Requesters must re-present words.
- busy_o = (state != IDLE) | out_valid_o.
- grant_o: 01 in GRANT0, 10 in GRANT1.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with both valids high → all outputs 0, grant_o = 00; first grant goes to requester 0.
- Single word: req0 sends 40'h00_0000_C0AA with last = 1, out_ready_i = 1, valid at cycle 0 → out_valid_o = 1, out_data_o = 40'h00_0000_C0AA, out_src_o = 0 at cycle 2; grant_o returns to 00 at cycle 2.
- Contention: both valid, 2-word bursts from each →
  - req0 words appear first, then one bubble, then req1 words.
  - Repeating the pattern with the pointer now at 1 serves req1 first.
- Burst cap: MAX_BURST = 4, req1 streams 6 words with no last while req0 is waiting →
  - 4 req1 words, then req0's burst, then the remaining 2 req1 words.
- Backpressure: out_ready_i = 0 for 5 cycles during a burst →
  - out_data_o stable; req ready low after the first load.
  - No words lost or duplicated; the order of 3 words is preserved after out_ready_i rises.
- Mid-burst reset: assert rst_n = 0 after word 2 of a 4-word req0 burst →
  - Next cycle out_valid_o = 0, grant_o = 00, counter = 0.
  - After release, a new req1 burst is served correctly.
